// File: rtl/hazard_unit.sv
// hazard_unit: load-use, execute-wait and taken-branch flush controller for the 5-stage MIPS pipeline.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module hazard_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int STAT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [4:0]        fdRsAddr_i,
    input  logic [4:0]        fdRtAddr_i,
    input  logic              fdUsesRt_i,
    input  logic              deMemToRead_i,
    input  logic              deRegWrite_i,
    input  logic [4:0]        deRtAddr_i,
    input  logic              exBusy_i,
    input  logic              branchTaken_i,
    input  logic              clearStats_i,
    output logic              pcWrite_o,
    output logic              fdWrite_o,
    output logic              deBubble_o,
    output logic              deHold_o,
    output logic              fdFlush_o,
    output logic              deFlush_o,
    output logic [1:0]        state_o,
    output logic [STAT_W-1:0] stallCycles_o,
    output logic [STAT_W-1:0] flushCount_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        EX_WAIT  = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    state_e     state_d, state_q;
    logic [1:0] flushCnt_d, flushCnt_q;
    logic       loadUse;

    assign loadUse = deMemToRead_i && deRegWrite_i && (deRtAddr_i != 5'd0) &&
                     ((deRtAddr_i == fdRsAddr_i) || (fdUsesRt_i && (deRtAddr_i == fdRtAddr_i)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            flushCnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    // The branch cycle itself is the first flush cycle; FLUSH covers the remaining ones.
    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        pcWrite_o  = 1'b1;
        fdWrite_o  = 1'b1;
        deBubble_o = 1'b0;
        deHold_o   = 1'b0;
        fdFlush_o  = 1'b0;
        deFlush_o  = 1'b0;

        if (state_q == FLUSH) begin
            fdFlush_o = 1'b1;
            deFlush_o = 1'b1;
            if (flushCnt_q >= FLUSH_LAST) begin
                state_d    = RUN;
                flushCnt_d = 2'd0;
            end else begin
                flushCnt_d = flushCnt_q + 2'd1;
            end
        end else if (branchTaken_i) begin
            fdFlush_o = 1'b1;
            deFlush_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d    = FLUSH;
                flushCnt_d = 2'd1;
            end else begin
                state_d    = RUN;
                flushCnt_d = 2'd0;
            end
        end else if (exBusy_i) begin
            pcWrite_o = 1'b0;
            fdWrite_o = 1'b0;
            deHold_o  = 1'b1;
            state_d   = EX_WAIT;
        end else if (loadUse && (state_q != LU_STALL)) begin
            pcWrite_o  = 1'b0;
            fdWrite_o  = 1'b0;
            deBubble_o = 1'b1;
            state_d    = LU_STALL;
        end else begin
            state_d = RUN;
        end

        // Outputs must show the idle pattern while reset is held, whatever the inputs do.
        if (!rst_ni) begin
            pcWrite_o  = 1'b1;
            fdWrite_o  = 1'b1;
            deBubble_o = 1'b0;
            deHold_o   = 1'b0;
            fdFlush_o  = 1'b0;
            deFlush_o  = 1'b0;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_STATS_EN
    logic              branchAccept;
    logic [STAT_W-1:0] stallCycles_d, stallCycles_q;
    logic [STAT_W-1:0] flushCount_d, flushCount_q;

    assign branchAccept = branchTaken_i && (state_q != FLUSH);

    always_comb begin
        stallCycles_d = stallCycles_q;
        flushCount_d  = flushCount_q;
        if (clearStats_i) begin
            stallCycles_d = '0;
            flushCount_d  = '0;
        end else begin
            if (!pcWrite_o && (stallCycles_q != '1)) begin
                stallCycles_d = stallCycles_q + STAT_W'(1);
            end
            if (branchAccept && (flushCount_q != '1)) begin
                flushCount_d = flushCount_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stallCycles_q <= '0;
            flushCount_q  <= '0;
        end else begin
            stallCycles_q <= stallCycles_d;
            flushCount_q  <= flushCount_d;
        end
    end

    assign stallCycles_o = stallCycles_q;
    assign flushCount_o  = flushCount_q;
`else
    logic unusedStats;

    assign unusedStats   = clearStats_i;
    assign stallCycles_o = '0;
    assign flushCount_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed scenarios then randomized traffic, checked against
// an action-level model (each cycle is FLUSH, HOLD, BUBBLE or NORMAL).
module tb_hazard_unit;

    localparam int FC  = 2;
    localparam int SW  = 2;
    localparam int SAT = (1 << SW) - 1;

    localparam int A_NORMAL = 0;
    localparam int A_BUBBLE = 1;
    localparam int A_HOLD   = 2;
    localparam int A_FLUSH  = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [4:0]    fdRsAddr_i = '0;
    logic [4:0]    fdRtAddr_i = '0;
    logic          fdUsesRt_i = 1'b0;
    logic          deMemToRead_i = 1'b0;
    logic          deRegWrite_i = 1'b0;
    logic [4:0]    deRtAddr_i = '0;
    logic          exBusy_i = 1'b0;
    logic          branchTaken_i = 1'b0;
    logic          clearStats_i = 1'b0;
    logic          pcWrite_o, fdWrite_o, deBubble_o, deHold_o, fdFlush_o, deFlush_o;
    logic [1:0]    state_o;
    logic [SW-1:0] stallCycles_o, flushCount_o;

    int vectors = 0;
    int miscompares = 0;

    // Model state: remaining flush cycles and what the previous cycle did.
    int flushLeft;
    bit lastBubble, lastHold;
    int mStall, mFlush;

    always #5 clk_i = ~clk_i;

    hazard_unit #(.FLUSH_CYCLES(FC), .STAT_W(SW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fdRsAddr_i(fdRsAddr_i), .fdRtAddr_i(fdRtAddr_i), .fdUsesRt_i(fdUsesRt_i),
        .deMemToRead_i(deMemToRead_i), .deRegWrite_i(deRegWrite_i), .deRtAddr_i(deRtAddr_i),
        .exBusy_i(exBusy_i), .branchTaken_i(branchTaken_i), .clearStats_i(clearStats_i),
        .pcWrite_o(pcWrite_o), .fdWrite_o(fdWrite_o), .deBubble_o(deBubble_o),
        .deHold_o(deHold_o), .fdFlush_o(fdFlush_o), .deFlush_o(deFlush_o),
        .state_o(state_o), .stallCycles_o(stallCycles_o), .flushCount_o(flushCount_o)
    );

    task automatic modelReset();
        flushLeft  = 0;
        lastBubble = 1'b0;
        lastHold   = 1'b0;
        mStall     = 0;
        mFlush     = 0;
    endtask

    task automatic applyStimulus(input bit br, input bit busy, input bit memRd, input bit regW,
                                 input logic [4:0] deRt, input logic [4:0] rs, input logic [4:0] rt,
                                 input bit usesRt, input bit clr);
        @(negedge clk_i);
        branchTaken_i = br;
        exBusy_i      = busy;
        deMemToRead_i = memRd;
        deRegWrite_i  = regW;
        deRtAddr_i    = deRt;
        fdRsAddr_i    = rs;
        fdRtAddr_i    = rt;
        fdUsesRt_i    = usesRt;
        clearStats_i  = clr;
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0]      expCtl, obsCtl;
        logic [2*SW-1:0] expStat, obsStat;
        int              action;
        int              expState;
        bit              lu;
        #1;
        lu = deMemToRead_i && deRegWrite_i && (deRtAddr_i != 0) &&
             ((deRtAddr_i == fdRsAddr_i) || (fdUsesRt_i && deRtAddr_i == fdRtAddr_i));

        if (!rst_ni) begin
            action   = A_NORMAL;
            expState = 0;
        end else begin
            if (flushLeft > 0 || branchTaken_i) action = A_FLUSH;
            else if (exBusy_i)                  action = A_HOLD;
            else if (lu && !lastBubble)         action = A_BUBBLE;
            else                                action = A_NORMAL;
            expState = (flushLeft > 0) ? 3 : lastBubble ? 1 : lastHold ? 2 : 0;
        end

        case (action)
            A_BUBBLE: expCtl[7:2] = 6'b001000;
            A_HOLD:   expCtl[7:2] = 6'b000100;
            A_FLUSH:  expCtl[7:2] = 6'b110011;
            default:  expCtl[7:2] = 6'b110000;
        endcase
        expCtl[1:0] = 2'(expState);
        obsCtl = {pcWrite_o, fdWrite_o, deBubble_o, deHold_o, fdFlush_o, deFlush_o, state_o};

`ifdef HAZARD_STATS_EN
        expStat = {SW'(mStall), SW'(mFlush)};
`else
        expStat = '0;
`endif
        obsStat = {stallCycles_o, flushCount_o};

        vectors++;
        assert (obsCtl === expCtl) else begin
            miscompares++;
            $error("[TB] FAIL %s ctl {pc,fd,bub,hold,ff,df,st} observed=%b expected=%b", tag, obsCtl, expCtl);
        end
        vectors++;
        assert (obsStat === expStat) else begin
            miscompares++;
            $error("[TB] FAIL %s stats {stall,flush} observed=%h expected=%h", tag, obsStat, expStat);
        end

        if (rst_ni) begin
            if (clearStats_i) begin
                mStall = 0;
                mFlush = 0;
            end else begin
                if ((action == A_BUBBLE || action == A_HOLD) && mStall < SAT) mStall++;
                if (action == A_FLUSH && flushLeft == 0 && mFlush < SAT) mFlush++;
            end
            if (action == A_FLUSH) flushLeft = (flushLeft > 0) ? flushLeft - 1 : FC - 1;
            lastBubble = (action == A_BUBBLE);
            lastHold   = (action == A_HOLD);
        end
    endtask

    task automatic asyncReset(input string tag);
        #2;
        rst_ni = 1'b0;
        modelReset();
        checkOutput(tag);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        modelReset();
        #2;
        checkOutput("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Load-use on rs, then release the following cycle.
        applyStimulus(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0); checkOutput("lu_rs_bubble");
        applyStimulus(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0); checkOutput("lu_rs_release");
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOutput("idle");

        // Register 0 and unused rt never stall; used rt does.
        applyStimulus(0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0); checkOutput("lu_r0");
        applyStimulus(0, 0, 1, 1, 5'd7, 5'd1, 5'd7, 0, 0); checkOutput("lu_rt_unused");
        applyStimulus(0, 0, 1, 1, 5'd7, 5'd1, 5'd7, 1, 0); checkOutput("lu_rt_used");
        applyStimulus(0, 0, 1, 1, 5'd7, 5'd1, 5'd7, 1, 0); checkOutput("lu_rt_release");
        applyStimulus(0, 0, 1, 0, 5'd7, 5'd7, 5'd7, 1, 0); checkOutput("lu_no_regwrite");

        // Execute wait with a pending load-use: hold dominates, bubble after busy falls.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0); checkOutput("ex_hold");
        end
        applyStimulus(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0); checkOutput("ex_fall_bubble");
        applyStimulus(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0); checkOutput("ex_after");

        // Branch with exBusy pending; second branch during flush is ignored.
        applyStimulus(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOutput("br_flush1");
        applyStimulus(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOutput("br_flush2");
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOutput("br_after");

        // Reset dropped mid-flush, with branchTaken_i still high.
        applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOutput("rst_pre_flush");
        asyncReset("rst_mid_flush");
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOutput("rst_no_residual");

        // Five load-use stalls saturate the 2-bit counter, then clear.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 1, 5'd3, 5'd3, 5'd0, 0, 0); checkOutput("stat_bubble");
            applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOutput("stat_gap");
        end
        applyStimulus(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1); checkOutput("stat_clear");
        applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); checkOutput("stat_cleared");

        // Randomized traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0),
                          ($urandom_range(0, 15) == 0));
            checkOutput("rand");
            if ($urandom_range(0, 99) == 0) asyncReset("rand_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
